// File: rtl/wb_pkg.sv
// Shared widths and entry type for the writeback queue.
// Imported by wb_fifo2in and writeback_queue.
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_REGS   = 1 << DEF_ADDR_W;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2in.sv
// In-order FIFO, two ordered write ports (0 before 1), one read port.
// Ports: clk/rst_n/i_flush, i_we*/i_dest*/i_data*, i_re, head, count, entries.
module wb_fifo2in
  import wb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_flush,
  input  logic                           i_we0,
  input  logic [ADDR_W-1:0]              i_dest0,
  input  logic [DATA_W-1:0]              i_data0,
  input  logic                           i_we1,
  input  logic [ADDR_W-1:0]              i_dest1,
  input  logic [DATA_W-1:0]              i_data1,
  input  logic                           i_re,
  output logic [ADDR_W-1:0]              o_dest,
  output logic [DATA_W-1:0]              o_data,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic [DEPTH-1:0]               o_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_ent_dest
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]                 r_wp;
  logic [AW-1:0]                 r_rp;
  logic [CW-1:0]                 r_count;
  logic [DEPTH-1:0]              r_vld;
  logic [DEPTH-1:0]              w_vld_n;
  logic [DEPTH-1:0][ADDR_W-1:0]  r_dest;
  logic [DEPTH-1:0][DATA_W-1:0]  r_data;
  logic [AW-1:0]                 w_wa1;

  // Port 1 lands behind port 0 when both write in one cycle.
  assign w_wa1 = i_we0 ? r_wp + AW'(1) : r_wp;

  // Pop clears before pushes set: a full FIFO may reuse the head slot.
  always_comb begin
    w_vld_n = r_vld;
    if (i_re)  w_vld_n[r_rp]  = 1'b0;
    if (i_we0) w_vld_n[r_wp]  = 1'b1;
    if (i_we1) w_vld_n[w_wa1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      r_wp    <= r_wp + AW'(i_we0) + AW'(i_we1);
      r_rp    <= r_rp + AW'(i_re);
      r_count <= r_count + CW'(i_we0)
               + CW'(i_we1) - CW'(i_re);
      r_vld   <= w_vld_n;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we0) begin
      r_dest[r_wp] <= i_dest0;
      r_data[r_wp] <= i_data0;
    end
    if (i_we1) begin
      r_dest[w_wa1] <= i_dest1;
      r_data[w_wa1] <= i_data1;
    end
  end

  assign o_dest     = r_dest[r_rp];
  assign o_data     = r_data[r_rp];
  assign o_count    = r_count;
  assign o_vld      = r_vld;
  assign o_ent_dest = r_dest;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: arbitrates ALU/load writes into a FIFO, drives one
// write per cycle (destination/DataReg/wr_en) plus a pending-write mask.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic [ADDR_W-1:0]        destination,
  output logic [DATA_W-1:0]        DataReg,
  output logic                     wr_en,
  output logic [(1<<ADDR_W)-1:0]   pending_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int NREG = 1 << ADDR_W;

  logic [CW-1:0]                w_count;
  logic [CW:0]                  w_free;
  logic                         w_pop;
  logic                         w_conflict;
  logic                         w_mem_acc;
  logic                         w_alu_acc;
  logic [ADDR_W-1:0]            w_head_dest;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0]             w_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_dest;
  logic [NREG-1:0]              w_mask;
  logic                         r_rr;
  logic                         r_wr_en;
  logic [ADDR_W-1:0]            r_dest;
  logic [DATA_W-1:0]            r_data;

  assign w_pop = (w_count != '0) && !flush;

  // Slots available this edge, including the one freed by the pop.
  assign w_free = (CW+1)'(DEPTH) - {1'b0, w_count}
                + (CW+1)'(w_count != '0);

  assign w_conflict = (w_free == (CW+1)'(1))
                    && alu_valid && mem_valid;

  // r_rr = 0 favours mem, 1 favours alu on a single-slot conflict.
  assign mem_ready = !flush && (w_free != '0)
                   && !(w_conflict && r_rr);
  assign alu_ready = !flush && (w_free != '0)
                   && !(w_conflict && !r_rr);

  assign w_mem_acc = mem_valid && mem_ready;
  assign w_alu_acc = alu_valid && alu_ready;

  wb_fifo2in #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_we0      (w_mem_acc),
    .i_dest0    (mem_dest),
    .i_data0    (mem_data),
    .i_we1      (w_alu_acc),
    .i_dest1    (alu_dest),
    .i_data1    (alu_data),
    .i_re       (w_pop),
    .o_dest     (w_head_dest),
    .o_data     (w_head_data),
    .o_count    (w_count),
    .o_vld      (w_vld),
    .o_ent_dest (w_ent_dest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= 1'b0;
      r_wr_en <= 1'b0;
      r_dest  <= '0;
      r_data  <= '0;
    end else begin
      if (w_conflict && !flush) r_rr <= !r_rr;
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_dest <= w_head_dest;
        r_data <= w_head_data;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_vld[i]) w_mask[w_ent_dest[i]] = 1'b1;
    if (r_wr_en) w_mask[r_dest] = 1'b1;
  end

  assign destination  = r_dest;
  assign DataReg      = r_data;
  assign wr_en        = r_wr_en;
  assign pending_mask = w_mask;
  assign count        = w_count;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: vector table,
// directed corner sequences, and random traffic vs a queue model.
module tb_writeback_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic [3:0]  destination;
  logic [31:0] DataReg;
  logic        wr_en;
  logic [15:0] pending_mask;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  writeback_queue #(
    .DATA_W (32),
    .ADDR_W (4),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alu_valid    (alu_valid),
    .alu_dest     (alu_dest),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_dest     (mem_dest),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .destination  (destination),
    .DataReg      (DataReg),
    .wr_en        (wr_en),
    .pending_mask (pending_mask),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        av;
    logic [3:0]  ad;
    logic [31:0] adat;
    logic        mv;
    logic [3:0]  md;
    logic [31:0] mdat;
    logic        ewr;
    logic [3:0]  edst;
    logic [31:0] edat;
    logic [15:0] emask;
    logic [2:0]  ecnt;
    logic        ear;
    logic        emr;
  } vec_t;

  vec_t tbl [9];

  // Reference model: queued writes in order, the output register, rr flag.
  wb_entry_t   q[$];
  logic        m_wr;
  logic [3:0]  m_dest;
  logic [31:0] m_data;
  logic        m_rr;
  logic        s_mr;
  logic        s_ar;
  int          n_acc;
  int          n_dut_wr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic av,
                       input logic [3:0] ad, input logic [31:0] adat,
                       input logic mv, input logic [3:0] md,
                       input logic [31:0] mdat);
    flush     = fl;
    alu_valid = av;
    alu_dest  = ad;
    alu_data  = adat;
    mem_valid = mv;
    mem_dest  = md;
    mem_data  = mdat;
  endtask

  task automatic model_reset();
    q.delete();
    m_wr   = 1'b0;
    m_dest = '0;
    m_data = '0;
    m_rr   = 1'b0;
  endtask

  task automatic step(input logic fl, input logic av,
                      input logic [3:0] ad, input logic [31:0] adat,
                      input logic mv, input logic [3:0] md,
                      input logic [31:0] mdat);
    int          cnt;
    int          fr;
    logic        ea;
    logic        em;
    logic        conf;
    logic [15:0] emask;
    wb_entry_t   e;
    drive(fl, av, ad, adat, mv, md, mdat);
    cnt  = q.size();
    fr   = DEPTH - cnt + ((cnt != 0) ? 1 : 0);
    conf = 1'b0;
    if (fl || fr == 0) begin
      ea = 1'b0; em = 1'b0;
    end else if (fr >= 2) begin
      ea = 1'b1; em = 1'b1;
    end else if (av && mv) begin
      conf = 1'b1;
      em = !m_rr; ea = m_rr;
    end else begin
      ea = 1'b1; em = 1'b1;
    end
    emask = '0;
    foreach (q[i]) emask[q[i].dest] = 1'b1;
    if (m_wr) emask[m_dest] = 1'b1;
    @(negedge clk);
    s_mr = mem_ready;
    s_ar = alu_ready;
    if (wr_en) n_dut_wr++;
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, ea});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, em});
    chk("wr_en", {31'b0, wr_en}, {31'b0, m_wr});
    chk("destination", {28'b0, destination}, {28'b0, m_dest});
    chk("DataReg", DataReg, m_data);
    chk("pending_mask", {16'b0, pending_mask}, {16'b0, emask});
    chk("count", {29'b0, count}, cnt);
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_wr = 1'b0;
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        m_wr = 1'b1; m_dest = e.dest; m_data = e.data;
      end else begin
        m_wr = 1'b0;
      end
      if (mv && em) begin q.push_back('{md, mdat}); n_acc++; end
      if (av && ea) begin q.push_back('{ad, adat}); n_acc++; end
      if (conf) m_rr = !m_rr;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'd0, 32'h06280060, 1'b0, 4'd0, 32'h0,
               1'b0, 4'd0, 32'h0, 16'h0000, 3'd0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b0, 4'd0, 32'h0, 16'h0001, 3'd1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b1, 4'd0, 32'h06280060, 16'h0001, 3'd0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b0, 4'd0, 32'h06280060, 16'h0000, 3'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'd9, 32'h06080020, 1'b1, 4'd9, 32'h11111111,
               1'b0, 4'd0, 32'h06280060, 16'h0000, 3'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b0, 4'd0, 32'h06280060, 16'h0200, 3'd2, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b1, 4'd9, 32'h11111111, 16'h0200, 3'd1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b1, 4'd9, 32'h06080020, 16'h0200, 3'd0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
               1'b0, 4'd9, 32'h06080020, 16'h0000, 3'd0, 1'b1, 1'b1};

    model_reset();
    n_acc = 0;
    n_dut_wr = 0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_dest", {28'b0, destination}, 32'd0);
    chk("rst_data", DataReg, 32'd0);
    chk("rst_mask", {16'b0, pending_mask}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].fl, tbl[i].av, tbl[i].ad, tbl[i].adat,
            tbl[i].mv, tbl[i].md, tbl[i].mdat);
      @(negedge clk);
      chk($sformatf("v%0d_wr_en", i), {31'b0, wr_en}, {31'b0, tbl[i].ewr});
      chk($sformatf("v%0d_dest", i), {28'b0, destination},
          {28'b0, tbl[i].edst});
      chk($sformatf("v%0d_data", i), DataReg, tbl[i].edat);
      chk($sformatf("v%0d_mask", i), {16'b0, pending_mask},
          {16'b0, tbl[i].emask});
      chk($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, tbl[i].ecnt});
      chk($sformatf("v%0d_alu_rdy", i), {31'b0, alu_ready},
          {31'b0, tbl[i].ear});
      chk($sformatf("v%0d_mem_rdy", i), {31'b0, mem_ready},
          {31'b0, tbl[i].emr});
      @(posedge clk);
      #1;
    end

    // Fill with both producers every cycle; conflicts start at k=3.
    do_reset();
    n_acc = 0;
    n_dut_wr = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 4'(k), 32'hA000_0000 + k,
           1'b1, 4'(k + 8), 32'hB000_0000 + k);
      if (k >= 3 && k <= 6) begin
        chk($sformatf("rr_mem_k%0d", k), {31'b0, s_mr},
            (k % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("rr_alu_k%0d", k), {31'b0, s_ar},
            (k % 2 == 0) ? 32'd1 : 32'd0);
      end
    end
    repeat (8) idle();
    chk("fill_accepted", n_acc, 11);
    chk("fill_writes", n_dut_wr, 11);

    // Flush with three queued entries and both producers valid.
    do_reset();
    step(1'b0, 1'b1, 4'd1, 32'h1111_0001, 1'b1, 4'd2, 32'h2222_0002);
    step(1'b0, 1'b1, 4'd3, 32'h3333_0003, 1'b1, 4'd4, 32'h4444_0004);
    chk("pre_flush_count", {29'b0, count}, 32'd3);
    step(1'b1, 1'b1, 4'd5, 32'h5555_0005, 1'b1, 4'd6, 32'h6666_0006);
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_wr_en", {31'b0, wr_en}, 32'd0);
    chk("flush_mask", {16'b0, pending_mask}, 32'd0);
    idle();
    idle();

    // Asynchronous reset mid-cycle while a write is on the outputs.
    do_reset();
    step(1'b0, 1'b1, 4'd7, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0);
    idle();
    chk("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("arst_dest", {28'b0, destination}, 32'd0);
    chk("arst_data", DataReg, 32'd0);
    chk("arst_mask", {16'b0, pending_mask}, 32'd0);
    chk("arst_count", {29'b0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step(1'b0, 1'b1, 4'd12, 32'hCAFE_F00D, 1'b0, 4'd0, 32'd0);
    idle();
    idle();
    idle();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 25) == 0,
           ($urandom % 3) != 0, 4'($urandom), $urandom,
           ($urandom % 3) != 0, 4'($urandom), $urandom);
    end
    repeat (6) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
